// File: rtl/fetch_align_buffer_pkg.sv
// Shared types and helpers for the fetch alignment buffer.
package fetch_align_buffer_pkg;

    localparam int unsigned FETCH_DEPTH_DEFAULT = 4;

    // One instruction as presented to the fetch stage.
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic        compressed;
    } fetch_inst_type;

    // Which slice of the queue head (and next word) forms the current instruction.
    typedef enum logic [1:0] {
        SEL_FULL_LO  = 2'd0,
        SEL_COMP_LO  = 2'd1,
        SEL_COMP_HI  = 2'd2,
        SEL_STRADDLE = 2'd3
    } fetch_sel_e;

    // A parcel is compressed unless its two low bits are both set.
    function automatic logic is_compressed(input logic [1:0] lsb);
        return lsb != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_align_buffer_word_fifo.sv
// Circular word queue feeding the alignment logic; exposes the head and the
// word behind it so a straddling instruction can be assembled.
module fetch_word_fifo
    import fetch_align_buffer_pkg::*;
#(
    parameter int unsigned FETCH_DEPTH = FETCH_DEPTH_DEFAULT,
    localparam int unsigned AW = $clog2(FETCH_DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [31:0]   push_data,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic [31:0]   head,
    output logic [31:0]   next_word
);

    logic [31:0]   mem [FETCH_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    // Storage write; flushed pushes are discarded.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking, flush clears the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign count     = count_q;
    assign head      = mem[rd_ptr];
    assign next_word = mem[rd_ptr + AW'(1)];

endmodule

// File: rtl/fetch_align_buffer.sv
// Fetch alignment buffer: prefetches aligned words from program memory and
// presents one instruction per cycle with its PC. Redirects flush the queue
// and drop responses that are still in flight.
// Optional macro FETCH_ALIGN_RVC_EN enables 16-bit compressed instructions
// and word-straddling 32-bit instructions; without it every instruction is a
// full aligned word.
module fetch_align_buffer
    import fetch_align_buffer_pkg::*;
#(
    parameter int unsigned FETCH_DEPTH = FETCH_DEPTH_DEFAULT,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        inst_compressed,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned CW = $clog2(FETCH_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(FETCH_DEPTH);

`ifdef FETCH_ALIGN_RVC_EN
    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFE;
`else
    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
`endif

    logic [CW-1:0]  q_count;
    logic [31:0]    q_head;
    logic [31:0]    q_next;
    logic           q_push;
    logic           q_pop;

    logic [CW-1:0]  outstanding_q;
    logic [CW-1:0]  outstanding_nxt;
    logic [CW-1:0]  drop_q;
    logic [31:0]    pc_q;
    logic [31:0]    addr_q;

    logic           req_fire;
    logic           fire;
    logic           cur_valid;
    fetch_inst_type cur;

    fetch_word_fifo #(
        .FETCH_DEPTH(FETCH_DEPTH)
    ) u_word_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (q_push),
        .push_data (mem_resp_data),
        .pop       (q_pop),
        .count     (q_count),
        .head      (q_head),
        .next_word (q_next)
    );

    // Request issue: queued words plus in-flight reads never exceed the queue depth.
    assign mem_req_valid = !reset && !redirect_valid &&
                           (({1'b0, q_count} + {1'b0, outstanding_q}) < DEPTH_LIM);
    assign mem_req_addr  = addr_q;
    assign req_fire      = mem_req_valid && mem_req_ready;

    // Responses still owed to a pre-redirect stream are dropped, not queued.
    assign q_push          = mem_resp_valid && (drop_q == '0) && !redirect_valid;
    assign outstanding_nxt = outstanding_q + CW'(req_fire) - CW'(mem_resp_valid);

`ifdef FETCH_ALIGN_RVC_EN
    logic       offset_q;
    fetch_sel_e sel;

    // Classify the current instruction from the halfword offset and its low bits.
    always_comb begin
        if (!offset_q) begin
            sel = is_compressed(q_head[1:0]) ? SEL_COMP_LO : SEL_FULL_LO;
        end else begin
            sel = is_compressed(q_head[17:16]) ? SEL_COMP_HI : SEL_STRADDLE;
        end
    end

    // Assemble the instruction; a straddle needs the following word as well.
    always_comb begin
        cur       = '0;
        cur.pc    = pc_q;
        cur_valid = (q_count != '0);
        unique case (sel)
            SEL_FULL_LO: begin
                cur.data = q_head;
            end
            SEL_COMP_LO: begin
                cur.data       = {16'h0000, q_head[15:0]};
                cur.compressed = 1'b1;
            end
            SEL_COMP_HI: begin
                cur.data       = {16'h0000, q_head[31:16]};
                cur.compressed = 1'b1;
            end
            SEL_STRADDLE: begin
                cur.data  = {q_next[15:0], q_head[31:16]};
                cur_valid = (q_count >= CW'(2));
            end
        endcase
    end

    // Only a compressed instruction in the low half leaves the head word in place.
    assign q_pop = fire && (offset_q || !cur.compressed);

    // Halfword offset within the head word; toggles on every compressed fire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            offset_q <= RESET_PC[1];
        end else if (redirect_valid) begin
            offset_q <= redirect_pc[1];
        end else if (fire) begin
            offset_q <= offset_q ^ cur.compressed;
        end
    end
`else
    logic unused_next;

    // Every instruction is the full head word.
    always_comb begin
        cur       = '0;
        cur.pc    = pc_q;
        cur.data  = q_head;
        cur_valid = (q_count != '0);
    end

    assign q_pop       = fire;
    assign unused_next = ^q_next;
`endif

    assign inst_valid      = cur_valid && !redirect_valid;
    assign fire            = inst_valid && inst_ready;
    assign inst_pc         = pc_q;
    assign inst_data       = (q_count != '0) ? cur.data : '0;
    assign inst_compressed = (q_count != '0) ? cur.compressed : 1'b0;

    // Fetch PC: redirect wins, otherwise advance by the size of the taken instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC & PC_MASK;
        end else if (redirect_valid) begin
            pc_q <= redirect_pc & PC_MASK;
        end else if (fire) begin
            pc_q <= pc_q + (cur.compressed ? 32'd2 : 32'd4);
        end
    end

    // Next word address to request; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= RESET_PC & 32'hFFFF_FFFC;
        end else if (redirect_valid) begin
            addr_q <= redirect_pc & 32'hFFFF_FFFC;
        end else if (req_fire) begin
            addr_q <= addr_q + 32'd4;
        end
    end

    // In-flight read count and stale-response drop count; a redirect marks
    // everything still outstanding after this cycle as stale.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            outstanding_q <= outstanding_nxt;
            if (redirect_valid) begin
                drop_q <= outstanding_nxt;
            end else if (mem_resp_valid && (drop_q != '0)) begin
                drop_q <= drop_q - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Self-checking bench for fetch_align_buffer. The reference model tracks only
// the architectural fetch PC, the next request address, the next expected
// response address and a count of stale reads; instruction contents come
// straight from the memory image.
module tb_fetch_align_buffer;

    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_ALIGN_RVC_EN
    localparam bit          RVC = 1'b1;
`else
    localparam bit          RVC = 1'b0;
`endif
    localparam logic [31:0] PCM = RVC ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;

    logic        clk;
    logic        reset;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_compressed;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    fetch_align_buffer #(
        .FETCH_DEPTH(DEPTH),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_compressed(inst_compressed),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        int unsigned cyc;
    } fire_t;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [31:0] img [256];
    pend_t       pend [$];
    fire_t       flog [$];
    int unsigned cyc;
    int unsigned lat_lo, lat_hi;
    bit          slow_en;
    logic [31:0] slow_addr;

    logic [31:0] m_pc, m_req, m_recv;
    int unsigned m_stale;

    logic        s_req_valid, s_inst_valid;
    logic [31:0] s_req_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return img[a[9:2]];
    endfunction

    // Expected instruction at a PC, straight from the memory image.
    function automatic void exp_inst(input logic [31:0] pc, output logic [31:0] data,
                                     output logic comp, output int unsigned need);
        logic [31:0] w0, w1;
        logic [15:0] h;
        w0 = word_at(pc);
        w1 = word_at(pc + 32'd4);
        h  = pc[1] ? w0[31:16] : w0[15:0];
        if (RVC && h[1:0] != 2'b11) begin
            data = {16'h0000, h}; comp = 1'b1; need = 1;
        end else if (RVC && pc[1]) begin
            data = {w1[15:0], h}; comp = 1'b0; need = 2;
        end else begin
            data = w0; comp = 1'b0; need = 1;
        end
    endfunction

    function automatic fire_t log_at(input int unsigned i);
        fire_t e;
        e.pc = '1; e.data = '1; e.cyc = 0;
        if (i < flog.size()) e = flog[i];
        return e;
    endfunction

    task automatic model_reset();
        m_pc    = RST_PC & PCM;
        m_req   = RST_PC & 32'hFFFF_FFFC;
        m_recv  = m_req;
        m_stale = 0;
        pend.delete();
    endtask

    task automatic idle_inputs();
        inst_ready     = 1'b0;
        mem_req_ready  = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
    endtask

    // One clock cycle: drive, compare against the model, then advance model and memory.
    task automatic cycle(input bit rdy, input bit mrdy, input bit redir, input logic [31:0] rpc);
        logic [31:0] ed, pw;
        logic        ec;
        int unsigned need, avail, total, lat;
        bit          ev, erq, resp;
        @(negedge clk);
        inst_ready     = rdy;
        mem_req_ready  = mrdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        resp           = (pend.size() > 0) && (pend[0].due <= cyc);
        mem_resp_valid = resp;
        mem_resp_data  = resp ? word_at(pend[0].addr) : $urandom;
        #2;
        pw = m_pc & 32'hFFFF_FFFC;
        exp_inst(m_pc, ed, ec, need);
        avail = (m_recv - pw) >> 2;
        total = ((m_req - pw) >> 2) + m_stale;
        ev    = !redir && (avail >= need);
        erq   = !redir && (total < DEPTH);
        chk("inst_valid", 32'(inst_valid), 32'(ev));
        chk("inst_pc", inst_pc, m_pc);
        chk("mem_req_valid", 32'(mem_req_valid), 32'(erq));
        chk("mem_req_addr", mem_req_addr, m_req);
        if (ev) begin
            chk("inst_data", inst_data, ed);
            chk("inst_compressed", 32'(inst_compressed), 32'(ec));
        end
        s_req_valid  = mem_req_valid;
        s_inst_valid = inst_valid;
        s_req_addr   = mem_req_addr;
        if (inst_valid && inst_ready) flog.push_back('{inst_pc, inst_data, cyc});
        if (mem_req_valid && mem_req_ready) begin
            lat = $urandom_range(lat_hi, lat_lo);
            if (slow_en && mem_req_addr == slow_addr) lat += 5;
            pend.push_back('{mem_req_addr, cyc + lat});
        end
        if (resp) void'(pend.pop_front());
        if (resp) begin
            if (m_stale > 0) m_stale--;
            else m_recv += 32'd4;
        end
        if (redir) begin
            m_stale += (m_req - m_recv) >> 2;
            m_pc   = rpc & PCM;
            m_req  = rpc & 32'hFFFF_FFFC;
            m_recv = m_req;
        end else begin
            if (erq && mrdy) m_req += 32'd4;
            if (ev && rdy) m_pc += ec ? 32'd2 : 32'd4;
        end
        chk("queue_overflow", 32'(((m_recv - (m_pc & 32'hFFFF_FFFC)) >> 2) > DEPTH), 32'd0);
        cyc++;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req_valid"}, 32'(mem_req_valid), 32'd0);
        chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_inst_pc"}, inst_pc, RST_PC);
        chk({tag, "_req_addr"}, mem_req_addr, RST_PC & 32'hFFFF_FFFC);
        chk({tag, "_inst_data"}, inst_data, 32'd0);
        chk({tag, "_compressed"}, 32'(inst_compressed), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        fire_t e0, e1, e2;
        int unsigned bad;
        reset = 1'b1;
        idle_inputs();
        cyc = 0; lat_lo = 1; lat_hi = 1; slow_en = 0; slow_addr = '0;
        for (int unsigned i = 0; i < 256; i++) img[i] = $urandom;
        img[0] = 32'h0000_0013;
        img[1] = 32'h0010_0093;
        model_reset();
        #3;
        check_reset_values("reset");
        @(negedge clk);
        reset = 1'b0;

        // Straight-line fetch at latency 1.
        flog.delete();
        repeat (8) cycle(1, 1, 0, '0);
        e0 = log_at(0); e1 = log_at(1);
        chk("sl_pc0", e0.pc, 32'h0);
        chk("sl_data0", e0.data, 32'h0000_0013);
        chk("sl_pc1", e1.pc, 32'h4);
        chk("sl_data1", e1.data, 32'h0010_0093);
        chk("sl_one_per_cycle", e1.cyc - e0.cyc, 32'd1);

        // Back-pressure: queue fills and requests stop, then drains in order.
        for (int unsigned i = 8; i < 12; i++) img[i] = 32'h0000_0013 | (i << 20);
        cycle(1, 1, 1, 32'h20);
        repeat (12) cycle(0, 1, 0, '0);
        chk("bp_req_stalled", 32'(s_req_valid), 32'd0);
        chk("bp_req_addr", s_req_addr, 32'h30);
        chk("bp_inst_held", 32'(s_inst_valid), 32'd1);
        flog.delete();
        repeat (10) cycle(1, 1, 0, '0);
        e0 = log_at(0); e1 = log_at(1); e2 = log_at(2);
        chk("bp_pc0", e0.pc, 32'h20);
        chk("bp_pc1", e1.pc, 32'h24);
        chk("bp_pc2", e2.pc, 32'h28);
        chk("bp_data1", e1.data, 32'h0090_0013);

        // Redirect with three reads outstanding.
        img[64] = 32'h1234_0001;
        img[65] = 32'h0000_0013;
        img[66] = 32'h0000_0013;
        lat_lo = 6; lat_hi = 6;
        cycle(1, 1, 1, 32'h40);
        repeat (3) cycle(1, 1, 0, '0);
        lat_lo = 1; lat_hi = 1;
        flog.delete();
        cycle(1, 1, 1, 32'h102);
        repeat (20) cycle(1, 1, 0, '0);
        e0 = log_at(0);
`ifdef FETCH_ALIGN_RVC_EN
        chk("rd_first_pc", e0.pc, 32'h102);
        chk("rd_first_data", e0.data, 32'h0000_1234);
`else
        chk("rd_first_pc", e0.pc, 32'h100);
        chk("rd_first_data", e0.data, 32'h1234_0001);
`endif
        bad = 0;
        foreach (flog[i]) if (flog[i].pc < 32'h100 || flog[i].pc > 32'h200) bad++;
        chk("rd_no_stale_pc", bad, 32'd0);

`ifdef FETCH_ALIGN_RVC_EN
        // Mixed compressed with a straddle whose second word arrives late.
        img[0] = 32'h0093_0001;
        img[1] = 32'h5555_1234;
        slow_en = 1; slow_addr = 32'h4;
        cycle(1, 1, 1, 32'h0);
        flog.delete();
        repeat (16) cycle(1, 1, 0, '0);
        slow_en = 0;
        e0 = log_at(0); e1 = log_at(1); e2 = log_at(2);
        chk("rvc_pc0", e0.pc, 32'h0);
        chk("rvc_data0", e0.data, 32'h0000_0001);
        chk("rvc_straddle_pc", e1.pc, 32'h2);
        chk("rvc_straddle_data", e1.data, 32'h1234_0093);
        chk("rvc_straddle_wait", e1.cyc - e0.cyc, 32'd6);
        chk("rvc_skip_pc4", e2.pc, 32'h6);
        chk("rvc_data2", e2.data, 32'h0000_5555);
`endif

        // Randomised traffic with occasional redirects.
        for (int unsigned i = 0; i < 256; i++) img[i] = $urandom;
        lat_lo = 1; lat_hi = 4;
        cycle(1, 1, 1, 32'h0);
        for (int unsigned i = 0; i < 3000; i++) begin
            cycle($urandom_range(99, 0) < 70, $urandom_range(99, 0) < 60,
                  $urandom_range(99, 0) < 3, $urandom_range(1023, 0));
        end

        // Asynchronous reset in the middle of traffic.
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        cyc++;
        lat_lo = 1; lat_hi = 1;
        flog.delete();
        repeat (8) cycle(1, 1, 0, '0);
        e0 = log_at(0);
        chk("restart_pc", e0.pc, RST_PC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_align_buffer.md
Name: fetch_align_buffer

Overview:
- Sits between program memory and the fetch stage.
- Prefetches aligned 32-bit words into a small queue and hands the fetch stage one instruction per cycle, with its PC and a compressed flag.
- Handles 16-bit compressed instructions, including 32-bit instructions that straddle a word boundary.
- Discards in-flight and queued words on a redirect from execute (mispredict or jump).

Parameters:
- FETCH_DEPTH, 4: word-queue entries; also the cap on queued plus outstanding requests (power of 2, ≥2).
- RESET_PC, 32'h0000_0000: first fetch PC after reset.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high reset.
- mem_req_valid, output, 1: word-read request.
- mem_req_ready, input, 1: memory accepts the request this cycle.
- mem_req_addr, output, 32: word-aligned read address (bits[1:0]=0).
- mem_resp_valid, input, 1: read data valid; in order, latency ≥1, never back-pressured.
- mem_resp_data, input, 32: read word.
- inst_valid, output, 1: instruction available to the fetch stage.
- inst_ready, input, 1: fetch stage takes the instruction.
- inst_data, output, 32: instruction; upper 16 bits are zero when compressed.
- inst_pc, output, 32: PC of inst_data (halfword aligned).
- inst_compressed, output, 1: inst_data[1:0] != 2'b11.
- redirect_valid, input, 1: flush and restart.
- redirect_pc, input, 32: new PC; bit 0 is ignored.

Behaviour:
- Reset values:
  - All outputs 0, except inst_pc = RESET_PC and mem_req_addr = RESET_PC & ~3.
  - Queue empty, outstanding count 0, drop count 0, offset = RESET_PC[1].
- Request issue:
  - mem_req_valid = !reset && !redirect_valid && (count + outstanding < FETCH_DEPTH).
  - On valid&&ready: mem_req_addr += 4 and outstanding increments.
  - Address wraps modulo 2^32.
- Response handling:
  - Every mem_resp_valid decrements outstanding.
  - If drop count > 0, the response decrements drop count and is discarded; otherwise it is pushed to the queue.
  - Push and pop in the same cycle are allowed.
  - Queue overflow cannot occur because of the issue rule; the bench asserts it never happens.
- Output selection (combinational from queue head H, next word N, offset o):
  - o=0, H[1:0]!=11: compressed = H[15:0]; valid if count ≥1.
  - o=0, H[1:0]==11: inst = H; valid if count ≥1.
  - o=1, H[17:16]!=11: compressed = H[31:16]; valid if count ≥1.
  - o=1, H[17:16]==11: inst = {N[15:0], H[31:16]} (straddle); valid only if count ≥2.
- inst_valid is forced 0 whenever redirect_valid=1.
- On inst_valid&&inst_ready:
  - inst_pc += 2 (compressed) or 4.
  - Pop/offset update:
    - o=0 compressed: no pop, o←1.
    - o=0 full: pop 1, o←0.
    - o=1 compressed: pop 1, o←0.
    - o=1 straddle: pop 1, o←1.
- Redirect (highest priority):
  - Same cycle: queue cleared, inst_pc ← {redirect_pc[31:1],0}, o ← redirect_pc[1], mem_req_addr ← {redirect_pc[31:2],00}.
  - Drop count ← outstanding after this cycle's request/response updates, so a response arriving in the redirect cycle is also discarded.
  - Any same-cycle fire or request is ignored; the first new request is issued the following cycle.
  - Back-to-back redirects accumulate drops correctly.
- Reset asserted mid-operation clears all state immediately. The memory is on the same reset, so no stale responses arrive afterwards.
- Latency: redirect → first inst_valid = 1 + memory latency (+1 word if the first instruction straddles).

Optional Feature:
- FETCH_ALIGN_RVC_EN.
- Defined: compressed and straddle handling as above.
- Undefined:
  - Every instruction is 32-bit and inst_compressed is tied 0.
  - Offset register and straddle path are removed.
  - inst_pc and redirect target are forced word-aligned (bits[1:0] ignored).
  - Every fire pops one word.

Decomposition:
- Shared package (common):
  - FETCH_DEPTH default.
  - fetch_inst_type struct {data, pc, compressed}.
  - function is_compressed(logic [1:0]).
- Sub-module fetch_word_fifo: parameterized circular word queue with push, pop, flush, count, and head/next read ports; pointers wrap mod FETCH_DEPTH.

Test Plan:
- Straight-line fetch: memory words at 0x0 = 0x00000013 and 0x4 = 0x00100093, latency 1, inst_ready=1 → instructions at PC 0x0 then 0x4, compressed=0, one per cycle after the first.
- Mixed compressed: word 0x0 = 0x00930001 (low half 0x0001, upper half 0x0093) → inst 0x00000001 @0x0 compressed; then straddle {word1[15:0], 0x0093} @0x2 compressed=0, with 0x4 never presented.
- Straddle wait: as above, with word 1 delayed 5 cycles → inst_valid stays 0 at PC 0x2 until word 1 arrives.
- Redirect with 3 requests outstanding: redirect_pc = 0x102 → the 3 responses are discarded; first inst_pc = 0x102 from word 0x100's upper half; no stale PC ever appears.
- Back-pressure: inst_ready=0 for 10 cycles → queue fills to FETCH_DEPTH, mem_req_valid drops to 0, no data loss; on release, PCs resume in order.
- Async reset asserted mid-stream → outputs return to reset values within the same cycle; after release, fetch restarts at RESET_PC.
